pc_gen: RTL and testbench

- Program-counter generation stage; sits directly upstream of the fetch stage.
- Produces the 32-bit word-aligned PC that fetch consumes.
- Handles sequential advance, redirect (branch/jump) with a flush bubble, stall back-pressure, halt, and misaligned-target detection.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared types and constants for the program-counter stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    localparam int XLEN                            = 32;
    localparam int INSTR_BYTES                     = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generator feeding fetch: sequential advance,
//               redirect with flush bubble, stall, halt and misaligned-target
//               detection. Optional issue counter enabled by PC_GEN_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
`ifdef PC_GEN_COUNTER_EN
    output logic [XLEN-1:0] issue_count,
`endif
    output logic            misaligned_err
);

    localparam logic [3:0]      c_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] c_STEP       = XLEN'(INSTR_BYTES);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [3:0]      r_cnt;
    logic            r_err;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [3:0]      w_cnt_nxt;
    logic            w_err_nxt;
    logic            w_advance;
    logic [XLEN-1:0] w_tgt_aligned;
    logic            w_tgt_mis;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else if (enable) begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_advance     = 1'b0;
        w_tgt_aligned = {redirect_target[XLEN-1:2], 2'b00};
        w_tgt_mis     = |redirect_target[1:0];

        if (halt) begin
            // Halt wins over everything; inside HALTED it simply holds.
            w_state_nxt = HALTED;
        end else if (redirect_valid && !r_err) begin
            w_pc_nxt  = w_tgt_aligned;
            w_cnt_nxt = 4'd0;
            if (w_tgt_mis) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = HALTED;
            end else begin
                w_state_nxt = FLUSH;
            end
        end else begin
            case (r_state)
                BOOT: w_state_nxt = RUN;
                RUN: begin
                    if (fetch_ready && !stall) begin
                        w_pc_nxt  = r_pc + c_STEP;
                        w_advance = 1'b1;
                    end
                end
                FLUSH: begin
                    if (r_cnt == c_FLUSH_LAST) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

`ifdef PC_GEN_COUNTER_EN
    logic [XLEN-1:0] r_issue_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_issue_count <= '0;
        end else if (enable && w_advance) begin
            r_issue_count <= r_issue_count + 1'b1;
        end
    end

    assign issue_count = r_issue_count;
`endif

    assign pc             = r_pc;
    assign pc_valid       = (r_state == RUN);
    assign misaligned_err = r_err;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Table-driven self-checking bench for pc_gen
//               (RESET_VECTOR = 0x100, FLUSH_CYCLES = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int          FC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        fetch_ready;
    logic        stall;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        misaligned_err;
`ifdef PC_GEN_COUNTER_EN
    logic [31:0] issue_count;
    logic [31:0] exp_count;
`endif

    int checks   = 0;
    int failures = 0;

    pc_gen #(
        .RESET_VECTOR (RV),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .fetch_ready     (fetch_ready),
        .stall           (stall),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_valid        (pc_valid),
`ifdef PC_GEN_COUNTER_EN
        .issue_count     (issue_count),
`endif
        .misaligned_err  (misaligned_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        en;
        logic        fr;
        logic        st;
        logic        ha;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        vld;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic en, input logic fr,
                                input logic st, input logic ha, input logic rv,
                                input logic [31:0] tgt, input logic [31:0] epc,
                                input logic vld, input logic err);
        vec_t v;
        v.rst = rst; v.en = en; v.fr = fr; v.st = st; v.ha = ha; v.rv = rv;
        v.tgt = tgt; v.pc = epc; v.vld = vld; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic prev_vld;
        int   cyc;

        reset = 1'b1; enable = 1'b1; fetch_ready = 1'b1; stall = 1'b0;
        halt = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        prev_vld = 1'b0;
`ifdef PC_GEN_COUNTER_EN
        exp_count = '0;
`endif
        #2;
        chk("reset_pc", -1, pc, RV);
        chk("reset_valid", -1, {31'd0, pc_valid}, 32'd0);
        chk("reset_err", -1, {31'd0, misaligned_err}, 32'd0);

        //   rst en fr st ha rv  tgt            pc             vld err
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h100,       1, 0); // BOOT -> RUN
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h104,       1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h108,       1, 0);
        add(0, 1, 1, 0, 0, 1, 32'h200,       32'h200,       0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h200,       0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h200,       1, 0);
        add(0, 1, 1, 1, 0, 0, 32'h0,         32'h200,       1, 0); // stall x3
        add(0, 1, 1, 1, 0, 0, 32'h0,         32'h200,       1, 0);
        add(0, 1, 1, 1, 0, 0, 32'h0,         32'h200,       1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h204,       1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h204,       1, 0); // !fetch_ready x3
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h204,       1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h204,       1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h208,       1, 0);
        add(0, 1, 1, 1, 0, 1, 32'h4000,      32'h4000,      0, 0); // redirect beats stall
        add(0, 1, 1, 1, 0, 0, 32'h0,         32'h4000,      0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h4000,      1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h4004,      1, 0);
        add(0, 1, 1, 0, 1, 1, 32'h8000,      32'h4004,      0, 0); // halt beats redirect
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h4004,      0, 0);
        add(0, 1, 1, 0, 0, 1, 32'h300,       32'h300,       0, 0); // resume from HALTED
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h300,       0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h300,       1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h304,       1, 0);
        add(0, 1, 1, 0, 0, 1, 32'h1000,      32'h1000,      0, 0);
        add(0, 0, 1, 0, 0, 1, 32'h5000,      32'h1000,      0, 0); // enable low x5 mid-flush
        add(0, 0, 1, 0, 0, 0, 32'h0,         32'h1000,      0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,         32'h1000,      0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,         32'h1000,      0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,         32'h1000,      0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h1000,      0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h1000,      1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h1004,      1, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,         32'h1004,      1, 0); // enable low in RUN
        add(0, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0); // wrap
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 0);
        add(0, 1, 1, 0, 0, 1, 32'h4002,      32'h4000,      0, 1); // misaligned
        add(0, 1, 1, 0, 0, 1, 32'h8000,      32'h4000,      0, 1);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h4000,      0, 1);
        add(1, 1, 1, 0, 0, 0, 32'h0,         RV,            0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h100,       1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h104,       1, 0);
        add(0, 1, 1, 0, 0, 1, 32'h700,       32'h700,       0, 0);
        add(1, 1, 1, 0, 0, 0, 32'h0,         RV,            0, 0); // reset mid-flush
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h100,       1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h104,       1, 0);
        add(0, 1, 1, 0, 1, 0, 32'h0,         32'h104,       0, 0); // halt in RUN
        add(0, 1, 1, 0, 0, 0, 32'h0,         32'h104,       0, 0);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset           = vecs[i].rst;
            enable          = vecs[i].en;
            fetch_ready     = vecs[i].fr;
            stall           = vecs[i].st;
            halt            = vecs[i].ha;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
`ifdef PC_GEN_COUNTER_EN
            if (vecs[i].rst)
                exp_count = '0;
            else if (prev_vld && vecs[i].en && vecs[i].fr && !vecs[i].st
                     && !vecs[i].ha && !vecs[i].rv)
                exp_count = exp_count + 1;
`endif
            @(posedge clock);
            #1;
            chk("pc", i, pc, vecs[i].pc);
            chk("pc_valid", i, {31'd0, pc_valid}, {31'd0, vecs[i].vld});
            chk("misaligned_err", i, {31'd0, misaligned_err}, {31'd0, vecs[i].err});
`ifdef PC_GEN_COUNTER_EN
            chk("issue_count", i, issue_count, exp_count);
`endif
            prev_vld = vecs[i].vld;
        end

        // Redirect taken in BOOT, then a bounded wait for the flush bubble to end.
        @(negedge clock);
        reset = 1'b1; enable = 1'b1; fetch_ready = 1'b1; stall = 1'b0;
        halt = 1'b0; redirect_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h900;
        @(posedge clock);
        #1;
        chk("boot_redirect_pc", 100, pc, 32'h900);
        chk("boot_redirect_valid", 100, {31'd0, pc_valid}, 32'd0);
        @(negedge clock);
        redirect_valid = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            cyc = k;
            if (pc_valid) break;
        end
        if (!pc_valid) cyc = 11;
        chk("flush_len", 101, cyc, FC);
        chk("flush_end_pc", 101, pc, 32'h900);
`ifdef PC_GEN_COUNTER_EN
        chk("count_after_reset", 101, issue_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
